// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path:
//   - uart_state_e   : receiver FSM state encoding (IDLE, START, DATA, STOP, BREAK)
//   - UART_DATA_BITS : data bits per frame (8N1)
//   - START_BIT/STOP_BIT : line levels of the frame delimiters
//   - maj3()         : 2-of-3 majority helper used by the majority-vote build
// No ports.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  localparam int   UART_DATA_BITS = 8;
  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchroniser for a single asynchronous input.
// Parameters:
//   RESET_VAL : value both flops take on reset (1 for an idle-high UART line)
// Ports:
//   i_clk   : destination clock
//   i_reset : synchronous, active-high reset
//   i_d     : asynchronous input
//   o_q     : synchronised output (two i_clk cycles of latency)
// -----------------------------------------------------------------------------
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= {2{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[0], i_d};
    end
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver driven by an oversampling strobe.
// Parameters:
//   OVERSAMPLE : sample_clk strobes per bit period (even, 4..64)
//   CNT_W      : width of the sub-bit tick counter (2**CNT_W > OVERSAMPLE)
// Ports:
//   ref_clk    : system clock, all logic on its rising edge
//   reset      : synchronous, active-high reset
//   sample_clk : one-cycle strobe, OVERSAMPLE per bit period
//   rx         : asynchronous serial line, idle high
//   out[0:7]   : received byte; out[7] holds the first (least significant) bit
//   valid      : one-cycle pulse, out carries a new good byte
//   frame_err  : one-cycle pulse, stop bit sampled low
//   busy       : high from start-bit confirmation until back in IDLE
// Handshake: valid/frame_err are single-cycle pulses with no back-pressure;
//   the consumer must capture out in the cycle valid is high, and a later good
//   frame overwrites out unconditionally.
// Build option:
//   UART_RX_MAJORITY_EN : each bit decision is the 2-of-3 majority of rx_s at
//   ticks OVERSAMPLE/2-2, OVERSAMPLE/2-1, OVERSAMPLE/2 of the bit. Undefined:
//   the single sample at tick OVERSAMPLE/2 is used. Decision timing and hence
//   latency are the same in both builds.
// The FSM state is held in r_state (type uart_state_e) for observation.
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 6
) (
  input  logic       ref_clk,
  input  logic       reset,
  input  logic       sample_clk,
  input  logic       rx,
  output logic [0:7] out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVERSAMPLE - 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic w_rx_s;
  logic w_bit;

  uart_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_tick,  w_tick_nxt;
  logic [2:0]       r_bit,   w_bit_nxt;
  logic [0:7]       r_shift, w_shift_nxt;
  logic [0:7]       r_out,   w_out_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_ferr,  w_ferr_nxt;
  logic             r_busy,  w_busy_nxt;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .i_clk   (ref_clk),
    .i_reset (reset),
    .i_d     (rx),
    .o_q     (w_rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Last two strobe samples of rx_s. At a decision strobe (tick OVERSAMPLE/2 of
  // the bit, counting the start-detect strobe as tick 0) the window is
  // r_hist[1], r_hist[0], rx_s, i.e. ticks OVERSAMPLE/2-2 .. OVERSAMPLE/2, so
  // the vote completes at the same strobe as the single-sample decision.
  logic [1:0] r_hist;

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      r_hist <= 2'b11;
    end else if (sample_clk) begin
      r_hist <= {r_hist[0], w_rx_s};
    end
  end

  assign w_bit = maj3(r_hist[1], r_hist[0], w_rx_s);
`else
  assign w_bit = w_rx_s;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_out_nxt   = r_out;
    w_busy_nxt  = r_busy;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;

    if (sample_clk) begin
      case (r_state)
        IDLE: begin
          if (w_rx_s == START_BIT) begin
            w_tick_nxt  = '0;
            w_state_nxt = START;
          end
        end

        START: begin
          if (r_tick == HALF_M1) begin
            if (w_bit == START_BIT) begin
              w_busy_nxt  = 1'b1;
              w_tick_nxt  = '0;
              w_bit_nxt   = '0;
              w_state_nxt = DATA;
            end else begin
              // Too short to be a start bit: treat as line noise.
              w_state_nxt = IDLE;
            end
          end else begin
            w_tick_nxt = r_tick + CNT_W'(1);
          end
        end

        DATA: begin
          if (r_tick == FULL_M1) begin
            w_tick_nxt  = '0;
            // New bit enters at index 0; the first bit ends up at index 7.
            w_shift_nxt = {w_bit, r_shift[0:6]};
            if (r_bit == LAST_BIT) begin
              w_state_nxt = STOP;
            end else begin
              w_bit_nxt = r_bit + 3'd1;
            end
          end else begin
            w_tick_nxt = r_tick + CNT_W'(1);
          end
        end

        STOP: begin
          if (r_tick == FULL_M1) begin
            w_tick_nxt = '0;
            if (w_bit == STOP_BIT) begin
              // Returning to IDLE at mid-stop lets a start edge in the second
              // half of the stop bit be caught (no idle gap needed).
              w_out_nxt   = r_shift;
              w_valid_nxt = 1'b1;
              w_busy_nxt  = 1'b0;
              w_state_nxt = IDLE;
            end else begin
              w_ferr_nxt  = 1'b1;
              w_state_nxt = BREAK;
            end
          end else begin
            w_tick_nxt = r_tick + CNT_W'(1);
          end
        end

        BREAK: begin
          // Stay here while the line is held low so it cannot re-trigger.
          if (w_rx_s == STOP_BIT) begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
          end
        end

        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_out   <= w_out_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign out       = r_out;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Drives uart_rx with serial frames built slot by slot (one slot = one
// sample_clk period of SC_DIV ref_clk cycles, OS slots per bit). Each frame
// sent pushes its expected outcome into exp_q; an independent monitor pops
// and compares whenever valid or frame_err pulses.
// exp_q entry: bit 8 = 1 for a framing error, bits 7:0 = expected byte.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int OS     = 16;
  localparam int SC_DIV = 4;
  localparam int BIT_CYC = OS * SC_DIV;

  logic       ref_clk = 1'b0;
  logic       reset;
  logic       sample_clk;
  logic       rx;
  logic [0:7] out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  always #5 ref_clk = ~ref_clk;

  uart_rx #(.OVERSAMPLE(OS), .CNT_W(6)) dut (
    .ref_clk    (ref_clk),
    .reset      (reset),
    .sample_clk (sample_clk),
    .rx         (rx),
    .out        (out),
    .valid      (valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_e;
  logic [7:0] last_good = 8'h00;
  logic       busy_seen = 1'b0;
  logic       track_gap = 1'b0;
  int         low_run = 0;
  int         max_low_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One sample_clk period: rx takes value v right after the previous strobe;
  // the strobe at the end of the slot sees it through the synchroniser.
  task automatic slot(input logic v);
    @(negedge ref_clk);
    rx = v;
    sample_clk = 1'b0;
    repeat (SC_DIV - 2) @(negedge ref_clk);
    @(negedge ref_clk);
    sample_clk = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) slot(1'b1);
  endtask

  // Full 8N1 frame, LSB first. glitch_bit >= 0 forces one low slot at the
  // middle (slot OS/2) of that data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int glitch_bit,
                            input logic [7:0] exp_b);
    if (stop_lvl) exp_q.push_back({1'b0, exp_b});
    else          exp_q.push_back({1'b1, 8'h00});
    for (int s = 0; s < OS; s++) slot(1'b0);
    for (int i = 0; i < 8; i++)
      for (int s = 0; s < OS; s++)
        slot((i == glitch_bit && s == OS / 2) ? 1'b0 : b[i]);
    for (int s = 0; s < OS; s++) slot(stop_lvl);
  endtask

  // Monitor: compare every output pulse against the head of exp_q.
  always @(negedge ref_clk) begin
    if (!reset) begin
      if (valid || frame_err) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b out=%0h, expected none",
                   valid, frame_err, out);
        end else begin
          exp_e = exp_q.pop_front();
          check("pulse_kind", {30'd0, valid, frame_err}, exp_e[8] ? 32'd1 : 32'd2);
          if (!exp_e[8]) begin
            check("rx_byte", {24'd0, out}, {24'd0, exp_e[7:0]});
            last_good = exp_e[7:0];
          end else begin
            check("out_held_on_ferr", {24'd0, out}, {24'd0, last_good});
          end
        end
      end
      if (busy) begin
        busy_seen = 1'b1;
        low_run = 0;
      end else begin
        low_run++;
        if (track_gap && low_run > max_low_run) max_low_run = low_run;
      end
    end
  end

  logic [7:0] rb;
  logic [7:0] glitch_exp;

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    sample_clk = 1'b0;
    repeat (3) @(negedge ref_clk);
    check("reset_out", {24'd0, out}, 32'h00);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_ferr", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    idle(20);

    // Single loopback byte.
    send_frame(8'hA5, 1'b1, -1, 8'hA5);
    idle(20);

    // Back-to-back frames with no idle gap; busy may only drop for the
    // window between mid-stop and the next mid-start.
    send_frame(8'h00, 1'b1, -1, 8'h00);
    track_gap = 1'b1;
    send_frame(8'hFF, 1'b1, -1, 8'hFF);
    send_frame(8'h55, 1'b1, -1, 8'h55);
    track_gap = 1'b0;
    check("b2b_busy_gap_within_bit", {31'd0, (max_low_run <= BIT_CYC)}, 32'd1);
    check("b2b_busy_gap_seen", {31'd0, (max_low_run > 0)}, 32'd1);
    idle(20);

    // Short low pulse: rejected at the start-bit check.
    busy_seen = 1'b0;
    for (int i = 0; i < 5; i++) slot(1'b0);
    idle(40);
    check("glitch_busy_never", {31'd0, busy_seen}, 32'd0);
    check("glitch_out_kept", {24'd0, out}, {24'd0, last_good});

    // Framing error followed by a held-low line.
    send_frame(8'h3C, 1'b0, -1, 8'h00);
    for (int i = 0; i < 3 * OS; i++) slot(1'b0);
    check("break_busy_high", {31'd0, busy}, 32'd1);
    idle(30);
    check("break_busy_cleared", {31'd0, busy}, 32'd0);
    check("break_out_kept", {24'd0, out}, {24'd0, last_good});

    // Reset in the middle of a frame (start + 4 data bits of 8'hC3).
    rb = 8'hC3;
    for (int s = 0; s < OS; s++) slot(1'b0);
    for (int i = 0; i < 4; i++)
      for (int s = 0; s < OS; s++) slot(rb[i]);
    @(negedge ref_clk);
    reset = 1'b1;
    rx = 1'b1;
    sample_clk = 1'b0;
    @(negedge ref_clk);
    check("midreset_out", {24'd0, out}, 32'h00);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_valid", {31'd0, valid}, 32'd0);
    last_good = 8'h00;
    reset = 1'b0;
    idle(20);
    send_frame(8'h81, 1'b1, -1, 8'h81);
    idle(10);

    // One-slot low glitch at mid-bit of data bit 3.
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'hFF;
`else
    glitch_exp = 8'hF7;
`endif
    send_frame(8'hFF, 1'b1, 3, glitch_exp);
    idle(10);

    // Random bytes with random (possibly zero) idle gaps.
    for (int k = 0; k < 24; k++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'b1, -1, rb);
      idle($urandom_range(0, 6));
    end

    idle(40);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
